// File: rtl/score_overlay.sv
// "SCORE" label plus 4-digit BCD score overlay for a VGA pixel stream.
// Two pix_en-qualified stages from (hc, vc, datas) to score_pix; the score counter runs at clk rate.
module score_overlay #(
   parameter logic [10:0] LABEL_X = 11'd400,
   parameter logic [10:0] DIGIT_X = 11'd452,
   parameter logic [10:0] ROW_TOP = 11'd100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic [10:0] hc,
   input  logic [10:0] vc,
   input  logic [46:0] datas,
   input  logic        score_inc,
   input  logic        game_over,
   input  logic        game_restart,
   output logic [15:0] score_bcd,
   output logic        score_pix
);

   logic [15:0] score_disp;
   logic [10:0] dy, kx, dx;
   logic        band;
   logic [3:0]  r_p1;
   logic        lab_hit_p1, dig_hit_p1;
   logic [5:0]  k_p1;
   logic [1:0]  d_p1;
   logic [2:0]  c_p1;
   logic [43:0] datas_p1;
   logic [3:0]  digit_sel;
   logic [7:0]  glyph;
   logic [43:0] label_sh;
   logic        unused_bits;

   assign unused_bits = ^datas[46:44];

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] res;
      logic        carry;
      res   = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (res[4*i +: 4] == 4'd9) begin
               res[4*i +: 4] = 4'd0;
            end else begin
               res[4*i +: 4] = res[4*i +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      return res;
   endfunction

   // Seven-segment style glyphs {a,b,c,d,e,f,g}, each segment two pixels thick.
   function automatic logic [7:0] glyph_row(input logic [3:0] dig, input logic [3:0] row);
      logic [6:0] seg;
      logic [7:0] upper, lower, out;
      case (dig)
         4'd0:    seg = 7'b1111110;
         4'd2:    seg = 7'b1101101;
         4'd3:    seg = 7'b1111001;
         4'd4:    seg = 7'b0110011;
         4'd5:    seg = 7'b1011011;
         4'd6:    seg = 7'b1011111;
         4'd7:    seg = 7'b1110000;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1111011;
         default: seg = 7'b0000000;
      endcase
      upper = {seg[1], seg[1], 3'b000, seg[5], seg[5], 1'b0};
      lower = {seg[2], seg[2], 3'b000, seg[4], seg[4], 1'b0};
      case (row)
         4'd2, 4'd3:   out = seg[6] ? 8'b11111110 : upper;
         4'd4, 4'd5:   out = upper;
         4'd6, 4'd7:   out = seg[0] ? 8'b11111110 : (upper | lower);
         4'd8, 4'd9:   out = lower;
         4'd10, 4'd11: out = seg[3] ? 8'b11111110 : lower;
         default:      out = 8'b00000000;
      endcase
      if (dig == 4'd1 && row >= 4'd2 && row <= 4'd11) out = 8'b00011000;
      return out;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         score_bcd <= 16'h0000;
      end else if (game_restart) begin
         score_bcd <= 16'h0000;
      end else if (!game_over && score_inc && score_bcd != 16'h9999) begin
         score_bcd <= bcd_inc(score_bcd);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         score_disp <= 16'h0000;
      end else if (pix_en && hc == 11'd0 && vc == 11'd0) begin
         score_disp <= score_bcd;
      end
   end

   // Wrapped (underflowed) differences are large, so the range compares reject them.
   assign dy   = vc - ROW_TOP;
   assign kx   = hc - LABEL_X;
   assign dx   = hc - DIGIT_X;
   assign band = dy < 11'd16;

   // Stage 1: region decode and bitmap capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p1       <= '0;
         lab_hit_p1 <= 1'b0;
         dig_hit_p1 <= 1'b0;
         k_p1       <= '0;
         d_p1       <= '0;
         c_p1       <= '0;
         datas_p1   <= '0;
      end else if (pix_en) begin
         r_p1       <= dy[3:0];
         lab_hit_p1 <= band && (kx < 11'd44);
         dig_hit_p1 <= band && (dx < 11'd32);
         k_p1       <= kx[5:0];
         d_p1       <= dx[4:3];
         c_p1       <= dx[2:0];
         datas_p1   <= datas[43:0];
      end
   end

   always_comb begin
      case (d_p1)
         2'd0:    digit_sel = score_disp[15:12];
         2'd1:    digit_sel = score_disp[11:8];
         2'd2:    digit_sel = score_disp[7:4];
         default: digit_sel = score_disp[3:0];
      endcase
   end

   assign glyph    = glyph_row(digit_sel, r_p1);
   assign label_sh = datas_p1 << k_p1;

   // Stage 2: pixel output
   always_ff @(posedge clk) begin
      if (rst) begin
         score_pix <= 1'b0;
      end else if (pix_en) begin
         score_pix <= (lab_hit_p1 && label_sh[43]) || (dig_hit_p1 && glyph[3'd7 - c_p1]);
      end
   end

endmodule

// File: tb/tb_score_overlay.sv
// Scoreboard bench for score_overlay: score counter scenarios plus pipelined pixel checks.
module tb_score_overlay;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_en = 1'b0;
   logic [10:0] hc = '0;
   logic [10:0] vc = '0;
   logic [46:0] datas = '0;
   logic        score_inc = 1'b0;
   logic        game_over = 1'b0;
   logic        game_restart = 1'b0;
   logic [15:0] score_bcd;
   logic        score_pix;

   int total = 0;
   int bad = 0;
   bit exp_q[$];

   localparam logic [46:0] B43  = 47'd1 << 43;
   localparam logic [46:0] B0   = 47'd1;
   localparam logic [46:0] ALL1 = '1;

   score_overlay dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hc(hc), .vc(vc), .datas(datas),
      .score_inc(score_inc), .game_over(game_over), .game_restart(game_restart),
      .score_bcd(score_bcd), .score_pix(score_pix)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic inc_n(input int n);
      pix_en    = 1'b0;
      score_inc = 1'b1;
      repeat (n) tick();
      score_inc = 1'b0;
   endtask

   // Drive one pixel; its expected score_pix comes out one qualified edge later.
   task automatic pstep(input logic [10:0] h, input logic [10:0] v, input logic [46:0] dat, input bit exp);
      bit e;
      pix_en = 1'b1;
      hc     = h;
      vc     = v;
      datas  = dat;
      exp_q.push_back(exp);
      tick();
      if (exp_q.size() >= 2) begin
         e = exp_q.pop_front();
         check($sformatf("pix_h%0d_v%0d", hc, vc), 32'(score_pix), 32'(e));
      end
   endtask

   initial begin
      repeat (2) tick();
      check("rst_score", 32'(score_bcd), 32'h0);
      check("rst_pix", 32'(score_pix), 32'h0);
      rst = 1'b0;
      tick();

      inc_n(1099);
      check("bcd_1099", 32'(score_bcd), 32'h1099);
      inc_n(1);
      check("bcd_1100", 32'(score_bcd), 32'h1100);
      inc_n(8899);
      check("bcd_9999", 32'(score_bcd), 32'h9999);
      inc_n(3);
      check("sat_9999", 32'(score_bcd), 32'h9999);

      game_restart = 1'b1;
      tick();
      game_restart = 1'b0;
      check("restart", 32'(score_bcd), 32'h0);
      inc_n(42);
      check("bcd_0042", 32'(score_bcd), 32'h0042);
      game_over = 1'b1;
      inc_n(1);
      check("over_freeze", 32'(score_bcd), 32'h0042);
      game_restart = 1'b1;
      score_inc    = 1'b1;
      tick();
      game_restart = 1'b0;
      score_inc    = 1'b0;
      game_over    = 1'b0;
      check("restart_over_inc", 32'(score_bcd), 32'h0);
      inc_n(5);
      game_restart = 1'b1;
      score_inc    = 1'b1;
      tick();
      game_restart = 1'b0;
      score_inc    = 1'b0;
      check("restart_inc", 32'(score_bcd), 32'h0);

      pstep(11'd0, 11'd0, ALL1, 1'b0);
      pstep(11'd400, 11'd102, B43, 1'b1);
      pstep(11'd444, 11'd102, ALL1, 1'b0);
      pstep(11'd443, 11'd102, B0, 1'b1);
      pstep(11'd399, 11'd102, ALL1, 1'b0);
      pstep(11'd400, 11'd99, ALL1, 1'b0);
      pstep(11'd400, 11'd115, B43, 1'b1);
      pstep(11'd400, 11'd116, ALL1, 1'b0);
      pstep(11'd2047, 11'd2047, ALL1, 1'b0);
      pstep(11'd476, 11'd102, '0, 1'b1);
      pstep(11'd452, 11'd102, '0, 1'b1);
      pstep(11'd476, 11'd100, '0, 1'b0);
      pstep(11'd476, 11'd112, '0, 1'b0);
      pstep(11'd479, 11'd106, '0, 1'b0);
      pstep(11'd484, 11'd102, ALL1, 1'b0);

      inc_n(1);
      check("bcd_0001", 32'(score_bcd), 32'h0001);
      pstep(11'd476, 11'd102, '0, 1'b1);
      pstep(11'd479, 11'd102, '0, 1'b1);
      pstep(11'd0, 11'd0, '0, 1'b0);
      pstep(11'd476, 11'd102, '0, 1'b0);
      pstep(11'd479, 11'd102, '0, 1'b1);
      pstep(11'd478, 11'd102, '0, 1'b0);
      pstep(11'd452, 11'd102, '0, 1'b1);
      pstep(11'd700, 11'd700, '0, 1'b0);

      pstep(11'd400, 11'd102, B43, 1'b1);
      pstep(11'd400, 11'd102, B43, 1'b1);
      check("pix_before_hold", 32'(score_pix), 32'h1);
      pix_en = 1'b0;
      hc     = 11'd700;
      vc     = 11'd700;
      datas  = '0;
      repeat (3) tick();
      check("pix_hold", 32'(score_pix), 32'h1);
      pstep(11'd700, 11'd700, '0, 1'b0);
      pstep(11'd700, 11'd700, '0, 1'b0);

      pstep(11'd400, 11'd102, B43, 1'b1);
      pstep(11'd400, 11'd102, B43, 1'b1);
      check("pix_pre_rst", 32'(score_pix), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      check("rst_mid_pix", 32'(score_pix), 32'h0);
      check("rst_mid_score", 32'(score_bcd), 32'h0);
      hc    = 11'd700;
      vc    = 11'd700;
      datas = '0;
      tick();
      check("post_rst_pix1", 32'(score_pix), 32'h0);
      tick();
      check("post_rst_pix2", 32'(score_pix), 32'h0);
      pstep(11'd476, 11'd102, '0, 1'b1);
      pstep(11'd700, 11'd700, '0, 1'b0);
      pstep(11'd700, 11'd700, '0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_overlay.md
SCORE_OVERLAY -- requirements
Module: score_overlay

Interface
REQ-001 SHALL have parameter LABEL_X, default 11'd400, meaning the leftmost screen column of the 44-px "SCORE" label.
REQ-002 SHALL have parameter DIGIT_X, default 11'd452, meaning the leftmost screen column of the 4-digit score field.
REQ-003 SHALL have parameter ROW_TOP, default 11'd100, meaning the first screen row of the 16-row text band.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-006 SHALL have port pix_en, input, 1, the pixel-rate qualifier; all pipeline and counter updates occur only on clk edges where pix_en=1, except reset and score events.
REQ-007 SHALL have ports hc and vc, input, 11 each, the current pixel column and row from VGA timing.
REQ-008 SHALL have port datas, input, 47, the label row bitmap from the score-name ROM for row vc; bit 43 is the leftmost pixel, and bits 46:44 are ignored.
REQ-009 SHALL have port score_inc, input, 1, a one-clk pulse that adds one point.
REQ-010 SHALL have port game_over, input, 1, a level signal that freezes the score.
REQ-011 SHALL have port game_restart, input, 1, a one-clk pulse that clears the score.
REQ-012 SHALL have port score_bcd, output, 16, the live score as 4 BCD digits (thousands in 15:12).
REQ-013 SHALL have port score_pix, output, 1, asserted when the text pixel is lit.

Function
REQ-014 Score counter: SHALL update on every clk edge, independent of pix_en.
REQ-015 Priority SHALL be game_restart > game_over > score_inc.
REQ-016 game_restart SHALL clear score_bcd to 16'h0000 on the next edge, even if score_inc is simultaneous.
REQ-017 score_inc SHALL be ignored while game_over=1.
REQ-018 Increment SHALL be BCD: a digit at 9 wraps to 0 and carries into the next digit.
REQ-019 At 16'h9999 the counter SHALL saturate, and further score_inc SHALL be ignored.
REQ-020 Display latch: score_disp SHALL load score_bcd on an edge with pix_en=1, hc=0, vc=0, and hold otherwise, so the displayed score changes only at frame start.
REQ-021 Stage 1, on pix_en: SHALL register row offset r=vc-ROW_TOP (4 bits), a label hit flag, a digit hit flag, label column k=hc-LABEL_X, digit index d=(hc-DIGIT_X)>>3, digit column c=(hc-DIGIT_X)&7, and datas[43:0].
REQ-022 Band membership SHALL be ROW_TOP<=vc<=ROW_TOP+15.
REQ-023 Label hit SHALL be band and LABEL_X<=hc<=LABEL_X+43.
REQ-024 Digit hit SHALL be band and DIGIT_X<=hc<=DIGIT_X+31.
REQ-025 Stage 2, on pix_en: score_pix SHALL be (label hit and datas_q[43-k]) or (digit hit and glyph(digit_d, r, c)).
REQ-026 d=0 SHALL select the thousands digit of score_disp.
REQ-027 Glyph ROM: SHALL be internal, combinational, 10 digits x 16 rows x 8 columns, with column 0 as the leftmost pixel.
REQ-028 Glyph rows 0,1,12..15 SHALL be blank.
REQ-029 Glyphs SHALL be drawn in rows 2..11 with 2-px-thick strokes, matching the label style.
REQ-030 Glyph 0 row 2 SHALL be 8'b11111110.
REQ-031 Glyph 1 row 2 SHALL be 8'b00011000.
REQ-032 Latency SHALL be exactly 2 pix_en-qualified edges from hc/vc/datas to score_pix.
REQ-033 Outputs SHALL hold their value when pix_en=0.
REQ-034 Coordinates outside both regions SHALL give score_pix=0, including hc/vc wrap from max back to 0.
REQ-035 Subtractions SHALL be 11-bit; region compares SHALL prevent any underflow result from being used.

Reset
REQ-036 rst=1 SHALL clear score_bcd, score_disp, all stage-1 and stage-2 registers, and score_pix to 0 on the next clk edge, regardless of pix_en.
REQ-037 rst SHALL have priority over game_restart, score_inc and pix_en.
REQ-038 A mid-frame rst SHALL cause score_pix=0 until two valid pix_en edges after rst deasserts.
REQ-039 The displayed score after a mid-frame rst SHALL be 0000 until the next frame start.

Verification
REQ-040 Scenario -- BCD carry: after reset, 1099 score_inc pulses -> score_bcd=16'h1099; one more pulse -> 16'h1100.
REQ-041 Scenario -- saturation: reach 16'h9999, then 3 more pulses -> stays 16'h9999.
REQ-042 Scenario -- priority: score=16'h0042 with game_over=1, then pulse score_inc -> 16'h0042; same edge as game_restart+score_inc -> 16'h0000.
REQ-043 Scenario -- label pixel: vc=102, hc=400, datas bit43=1 on two pix_en edges -> score_pix=1; with hc=444 -> score_pix=0.
REQ-044 Scenario -- digit/frame latch: score_bcd changes 0000->0001 mid-frame; pixel (DIGIT_X+24, row 102) stays glyph 0 (=1) until after the frame-start edge, then reflects glyph 1 bit 0 (=0).
REQ-045 Scenario -- reset mid-pipeline: with score_pix=1, assert rst for one edge -> score_pix=0 next edge; no stale 1 for two pix_en edges after release.
